pulse_gate_controller: RTL
==========================

PULSE_GATE_CONTROLLER -- requirements
Module: pulse_gate_controller

Interface
REQ-001 GATE_CYCLES, default 200000000, gate window length in clk_in cycles (legal range 1 .. 2^32-1).
REQ-002 CNT_WIDTH, default 8, width of the pulse count and result.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 start_in  input  1  request one measurement; sampled in IDLE only.
REQ-006 cont_in  input  1  continuous mode; sampled at result handshake.
REQ-007 abort_in  input  1  cancel the current measurement.
REQ-008 pulse_in  input  1  asynchronous pulse source.
REQ-009 busy_out  output  1  high in any state other than IDLE.
REQ-010 gate_out  output  1  high exactly during GATE state cycles.
REQ-011 cnt_out  output  CNT_WIDTH  latched result of the last completed window.
REQ-012 ovf_out  output  1  high if the last completed window saturated.
REQ-013 valid_out  output  1  result available.
REQ-014 ready_in  input  1  consumer accepts the result.

Function
REQ-015 pulse_in SHALL pass through a 2-flop synchronizer; only the synchronized signal (psync) is counted; input-to-count latency is 2 cycles.
REQ-016 The FSM SHALL have states IDLE, GATE, LATCH, HOLD; reset state IDLE.
REQ-017 IDLE: start_in=1 and abort_in=0 -> GATE; on entry the timer and running count clear to 0.
REQ-018 GATE: timer increments each cycle; when timer==GATE_CYCLES-1 -> LATCH, so gate_out is high for exactly GATE_CYCLES cycles; a count event in the final GATE cycle is included.
REQ-019 LATCH: single cycle; cnt_out<=running count, ovf_out<=saturation flag, valid_out<=1; -> HOLD.
REQ-020 HOLD: valid_out, cnt_out and ovf_out SHALL hold stable until valid_out&&ready_in; on that cycle, cont_in=1 -> GATE (timer/count cleared, no idle gap), else -> IDLE; valid_out drops in the next cycle unless re-asserted by a later LATCH.
REQ-021 The running count SHALL saturate at 2^CNT_WIDTH-1; any further event sets the saturation flag; no wrap-around.
REQ-022 abort_in=1 in GATE or LATCH -> IDLE next cycle; the window is discarded and cnt_out/ovf_out keep their previous values.
REQ-023 abort_in=1 in HOLD -> IDLE next cycle with valid_out=0; the held result counts as not delivered.
REQ-024 abort_in has priority over start_in, over gate expiry and over ready_in in the same cycle.
REQ-025 start_in outside IDLE SHALL be ignored (not queued).
REQ-026 Counting SHALL occur only in GATE; pulses in IDLE/LATCH/HOLD are not counted.

Reset
REQ-027 rst_in=1 SHALL force, on the next clock edge: state IDLE, timer 0, count 0, synchronizer and edge history 0, busy_out 0, gate_out 0, cnt_out 0, ovf_out 0, valid_out 0.
REQ-028 Reset mid-window or in HOLD SHALL discard all data; no result is produced.

Configuration
REQ-029 Macro PULSE_GATE_EDGE_EN defined: a count event is a rising edge of psync (psync=1, previous psync=0) in a GATE cycle; the history flop updates every cycle.
REQ-030 PULSE_GATE_EDGE_EN undefined: a count event is every GATE cycle with psync=1 (level counting).

Verification
REQ-031 GATE_CYCLES=10, 3 isolated 1-cycle pulses inside the window -> valid_out with cnt_out=3, ovf_out=0, in both macro modes.
REQ-032 GATE_CYCLES=10, pulse_in held high from 5 cycles before start -> level mode cnt_out=10; edge mode cnt_out=0.
REQ-033 CNT_WIDTH=3, GATE_CYCLES=10, level mode, pulse_in held high -> cnt_out=7, ovf_out=1.
REQ-034 cont_in=1, ready_in=1 held, GATE_CYCLES=10 -> gate_out high 10 cycles, low 2 cycles (LATCH, HOLD), repeating; one valid_out per window.
REQ-035 ready_in=0 for 20 cycles in HOLD -> valid_out, cnt_out and ovf_out stable; cnt_out=5 delivered on the first ready_in=1.
REQ-036 abort_in at gate cycle 4 after a previous result of 3 -> IDLE, busy_out=0, valid_out=0, cnt_out stays 3; rst_in in HOLD -> all outputs 0.

Source files
------------

// File: rtl/pulse_gate_controller.sv
// Counts synchronized pulses over a fixed gate window and hands the result off with valid/ready.
// Define PULSE_GATE_EDGE_EN to count rising edges of the synchronized pulse instead of high cycles.
module pulse_gate_controller #(
    parameter int unsigned GATE_CYCLES = 200000000,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 cont_in,
    input  logic                 abort_in,
    input  logic                 pulse_in,
    input  logic                 ready_in,
    output logic                 busy_out,
    output logic                 gate_out,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 ovf_out,
    output logic                 valid_out
);
    typedef enum logic [1:0] {StIdle, StGate, StLatch, StHold} state_e;

    localparam logic [31:0]          LastTick = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    state_e               r_state, w_state_next;
    logic [31:0]          r_timer, w_timer_next;
    logic [CNT_WIDTH-1:0] r_count, w_count_next;
    logic                 r_sat, w_sat_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_ovf_next;
    logic                 w_valid_next;
    logic                 r_sync1, r_psync;
    logic                 w_event;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= 1'b0;
            r_psync <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_psync <= r_sync1;
        end
    end

`ifdef PULSE_GATE_EDGE_EN
    logic r_psync_prev;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_psync_prev <= 1'b0;
        end else begin
            r_psync_prev <= r_psync;
        end
    end

    assign w_event = r_psync & ~r_psync_prev;
`else
    assign w_event = r_psync;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            cnt_out   <= '0;
            ovf_out   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_count   <= w_count_next;
            r_sat     <= w_sat_next;
            cnt_out   <= w_cnt_next;
            ovf_out   <= w_ovf_next;
            valid_out <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_count_next = r_count;
        w_sat_next   = r_sat;
        w_cnt_next   = cnt_out;
        w_ovf_next   = ovf_out;
        w_valid_next = valid_out;

        case (r_state)
            StIdle: begin
                if (start_in && !abort_in) begin
                    w_state_next = StGate;
                    w_timer_next = '0;
                    w_count_next = '0;
                    w_sat_next   = 1'b0;
                end
            end
            StGate: begin
                if (abort_in) begin
                    w_state_next = StIdle;
                end else begin
                    if (w_event) begin
                        if (r_count == CntMax) begin
                            w_sat_next = 1'b1;
                        end else begin
                            w_count_next = r_count + CNT_WIDTH'(1);
                        end
                    end
                    if (r_timer == LastTick) begin
                        w_state_next = StLatch;
                    end else begin
                        w_timer_next = r_timer + 32'd1;
                    end
                end
            end
            StLatch: begin
                if (abort_in) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next   = r_count;
                    w_ovf_next   = r_sat;
                    w_valid_next = 1'b1;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                // An abort retracts the held result even when the consumer is ready.
                if (abort_in) begin
                    w_state_next = StIdle;
                    w_valid_next = 1'b0;
                end else if (valid_out && ready_in) begin
                    w_valid_next = 1'b0;
                    if (cont_in) begin
                        w_state_next = StGate;
                        w_timer_next = '0;
                        w_count_next = '0;
                        w_sat_next   = 1'b0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign busy_out = (r_state != StIdle);
    assign gate_out = (r_state == StGate);

endmodule
